// File: rtl/pram_sequencer.sv
// -----------------------------------------------------------------------------
// pram_sequencer
//
// Purpose:
//   Address generator and output stage in front of the PRAM pattern memory.
//   A start command steps through a window of PRAM addresses at a programmable
//   rate. Each fetched byte is registered and presented as the active
//   switching pattern. Playback can be one-shot or looping, and stop aborts it
//   at once.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          level-sampled; accepted only in IDLE and only without stop
//   stop           level-sampled; aborts playback, highest priority
//   loop_en        1 = restart at base after the last step (sampled live)
//   base_addr      first PRAM address, latched on an accepted start
//   length         number of steps, latched on an accepted start
//   step_div       hold count per step, latched on an accepted start
//   pram_addr      registered address to the PRAM
//   pram_data      PRAM read data, combinational from pram_addr
//   pattern        registered active pattern
//   pattern_valid  one-cycle pulse when pattern is updated from the PRAM
//   busy           high whenever the sequencer is not IDLE
//   done           one-cycle pulse on one-shot completion or a length==0 start
//
// Build option:
//   SAFE_STOP_EN   when defined, pattern is forced to SAFE_PATTERN on the
//                  cycle playback ends by stop or one-shot completion.
//
// Step timing: FETCH takes one cycle, HOLD takes step_div+1 cycles, so one
// step lasts step_div+2 cycles.
// -----------------------------------------------------------------------------
module pram_sequencer #(
   parameter int                ADDR_W       = 16,
   parameter int                DATA_W       = 8,
   parameter int                DIV_W        = 16,
   parameter logic [DATA_W-1:0] SAFE_PATTERN = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic [DIV_W-1:0]  step_div,
   output logic [ADDR_W-1:0] pram_addr,
   input  logic [DATA_W-1:0] pram_data,
   output logic [DATA_W-1:0] pattern,
   output logic              pattern_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

`ifdef SAFE_STOP_EN
   localparam bit SAFE_STOP = 1'b1;
`else
   localparam bit SAFE_STOP = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] pattern_q, pattern_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              end_run;   // playback ends via stop or one-shot done

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned; an unassigned path would infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      pattern_d = pattern_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      len_d     = len_q;
      div_d     = div_q;
      end_run   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               if (length == '0) begin
                  // Empty window: report completion without ever going busy.
                  done_d = 1'b1;
               end else begin
                  base_d  = base_addr;
                  len_d   = length;
                  div_d   = step_div;
                  addr_d  = base_addr;
                  idx_d   = '0;
                  state_d = S_FETCH;
               end
            end
         end

         S_FETCH: begin
            if (stop) begin
               state_d = S_IDLE;
               end_run = 1'b1;
            end else begin
               // pram_addr has been stable for a full cycle, so pram_data is
               // settled and can be captured directly.
               pattern_d = pram_data;
               valid_d   = 1'b1;
               cnt_d     = div_q;
               state_d   = S_HOLD;
            end
         end

         S_HOLD: begin
            if (stop) begin
               state_d = S_IDLE;
               end_run = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q != len_q - 1'b1) begin
               idx_d   = idx_q + 1'b1;
               addr_d  = addr_q + 1'b1;   // wraps modulo 2^ADDR_W
               state_d = S_FETCH;
            end else if (loop_en) begin
               // loop_en is deliberately sampled live here, not latched.
               idx_d   = '0;
               addr_d  = base_q;
               state_d = S_FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               end_run = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (SAFE_STOP && end_run) begin
         pattern_d = SAFE_PATTERN;
      end

      busy_d = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         pattern_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         base_q    <= '0;
         len_q     <= '0;
         div_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pattern_q <= pattern_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         len_q     <= len_d;
         div_q     <= div_d;
      end
   end

   assign pram_addr     = addr_q;
   assign pattern       = pattern_q;
   assign pattern_valid = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
